adc_channel_sequencer: RTL and testbench

Round-robin scheduler for the MAX10 modular ADC command/response streams. It issues one single-sample conversion command per enabled slot, waits for the matching response, and latches each result into a per-slot register bank. It sits between the `adc_qsys` instance and the voltmeter/display logic, replacing the tied-off constant command channel. It also flags conversions that never return.

---
 rtl/adc_channel_sequencer.sv | 179 +++++++++++++++++
 tb/tb_adc_channel_sequencer.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_channel_sequencer.sv
// Round-robin command/response sequencer for the MAX10 modular ADC.
// Issues one conversion per enabled slot, banks each result and counts lost responses.
module adc_channel_sequencer #(
    parameter int NUM_CH  = 4,
    parameter int CH_BASE = 1,
    parameter int TIMEOUT = 1023
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        ch_mask,
    output logic                     command_valid,
    output logic [4:0]               command_channel,
    output logic                     command_startofpacket,
    output logic                     command_endofpacket,
    input  logic                     command_ready,
    input  logic                     response_valid,
    input  logic [4:0]               response_channel,
    input  logic [11:0]              response_data,
    output logic                     result_valid,
    output logic [2:0]               result_slot,
    output logic [11:0]              result_data,
    output logic [12*NUM_CH-1:0]     ch_data,
    output logic                     timeout_pulse,
    output logic [7:0]               err_count,
    output logic                     busy
);

    localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, PICK, CMD, WAIT_RSP} state_e;

    state_e                 state_q, state_d;
    logic [SW-1:0]          last_slot_q, last_slot_d;
    logic [SW-1:0]          cur_slot_q, cur_slot_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [4:0]             cmd_channel_q, cmd_channel_d;
    logic                   result_valid_q, result_valid_d;
    logic [2:0]             result_slot_q, result_slot_d;
    logic [11:0]            result_data_q, result_data_d;
    logic [12*NUM_CH-1:0]   ch_data_q, ch_data_d;
    logic                   timeout_pulse_q, timeout_pulse_d;
    logic [7:0]             err_count_q, err_count_d;
    logic                   busy_q, busy_d;

    logic [SW-1:0]          pick_slot;
    logic                   pick_found;
    logic                   rsp_match;
    logic                   timer_hit;
    logic                   rsp_done;

    // First enabled slot strictly after last_slot, wrapping NUM_CH-1 -> 0.
    always_comb begin
        logic [SW-1:0] idx;
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        pick_slot  = '0;
        pick_found = 1'b0;
        idx        = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = SW'((int'(last_slot_q) + k) % NUM_CH);
            if (!pick_found && ch_mask[idx]) begin
                pick_found = 1'b1;
                pick_slot  = idx;
            end
        end
    end

    assign rsp_match = response_valid && (response_channel == cmd_channel_q);
    assign timer_hit = (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d         = state_q;
        last_slot_d     = last_slot_q;
        cur_slot_d      = cur_slot_q;
        timer_d         = timer_q;
        cmd_channel_d   = cmd_channel_q;
        result_valid_d  = 1'b0;
        result_slot_d   = result_slot_q;
        result_data_d   = result_data_q;
        ch_data_d       = ch_data_q;
        timeout_pulse_d = 1'b0;
        err_count_d     = err_count_q;
        rsp_done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && (|ch_mask)) state_d = PICK;
            end
            PICK: begin
                if (pick_found) begin
                    cur_slot_d    = pick_slot;
                    cmd_channel_d = 5'(CH_BASE) + 5'(pick_slot);
                    state_d       = CMD;
                end else begin
                    state_d = IDLE;
                end
            end
            CMD: begin
                // Held regardless of enable/ch_mask until the ADC takes it.
                if (command_ready) begin
                    timer_d     = '0;
                    last_slot_d = cur_slot_q;
                    state_d     = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (rsp_match) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (cur_slot_q == SW'(i)) ch_data_d[12*i +: 12] = response_data;
                    end
                    result_valid_d = 1'b1;
                    result_slot_d  = 3'(cur_slot_q);
                    result_data_d  = response_data;
                    rsp_done       = 1'b1;
                end else if (timer_hit) begin
                    timeout_pulse_d = 1'b1;
                    if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                    rsp_done = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
                if (rsp_done) state_d = (enable && (|ch_mask)) ? PICK : IDLE;
            end
            default: state_d = IDLE;
        endcase

        cmd_valid_d = (state_d == CMD);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state_q         <= IDLE;
            last_slot_q     <= SW'(NUM_CH - 1);
            cur_slot_q      <= '0;
            timer_q         <= '0;
            cmd_valid_q     <= 1'b0;
            cmd_channel_q   <= '0;
            result_valid_q  <= 1'b0;
            result_slot_q   <= '0;
            result_data_q   <= '0;
            // NOTE: the result bank is reset because downstream display logic reads it before the first conversion.
            ch_data_q       <= '0;
            timeout_pulse_q <= 1'b0;
            err_count_q     <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_slot_q     <= last_slot_d;
            cur_slot_q      <= cur_slot_d;
            timer_q         <= timer_d;
            cmd_valid_q     <= cmd_valid_d;
            cmd_channel_q   <= cmd_channel_d;
            result_valid_q  <= result_valid_d;
            result_slot_q   <= result_slot_d;
            result_data_q   <= result_data_d;
            ch_data_q       <= ch_data_d;
            timeout_pulse_q <= timeout_pulse_d;
            err_count_q     <= err_count_d;
            busy_q          <= busy_d;
        end
    end

    assign command_valid         = cmd_valid_q;
    assign command_channel       = cmd_channel_q;
    assign command_startofpacket = cmd_valid_q;
    assign command_endofpacket   = cmd_valid_q;
    assign result_valid          = result_valid_q;
    assign result_slot           = result_slot_q;
    assign result_data           = result_data_q;
    assign ch_data               = ch_data_q;
    assign timeout_pulse         = timeout_pulse_q;
    assign err_count             = err_count_q;
    assign busy                  = busy_q;

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// Directed bench for adc_channel_sequencer: round-robin, masking, enable, timeouts and reset.
// A second instance with a short timeout exercises err_count saturation quickly.
module tb_adc_channel_sequencer;

    logic        sys_clk;
    logic        reset, enable, command_ready, response_valid;
    logic [3:0]  ch_mask;
    logic [4:0]  response_channel;
    logic [11:0] response_data;
    logic        command_valid, command_startofpacket, command_endofpacket;
    logic [4:0]  command_channel;
    logic        result_valid, timeout_pulse, busy;
    logic [2:0]  result_slot;
    logic [11:0] result_data;
    logic [47:0] ch_data;
    logic [7:0]  err_count;

    logic        s_reset, s_enable, s_ready, s_rsp_valid;
    logic [3:0]  s_mask;
    logic [4:0]  s_rsp_channel;
    logic [11:0] s_rsp_data;
    logic        s_cmd_valid, s_sop, s_eop, s_result_valid, s_timeout_pulse, s_busy;
    logic [4:0]  s_cmd_channel;
    logic [2:0]  s_result_slot;
    logic [11:0] s_result_data;
    logic [47:0] s_ch_data;
    logic [7:0]  s_err_count;

    int checks   = 0;
    int failures = 0;

    adc_channel_sequencer dut (
        .sys_clk(sys_clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
        .command_valid(command_valid), .command_channel(command_channel),
        .command_startofpacket(command_startofpacket), .command_endofpacket(command_endofpacket),
        .command_ready(command_ready), .response_valid(response_valid),
        .response_channel(response_channel), .response_data(response_data),
        .result_valid(result_valid), .result_slot(result_slot), .result_data(result_data),
        .ch_data(ch_data), .timeout_pulse(timeout_pulse), .err_count(err_count), .busy(busy)
    );

    adc_channel_sequencer #(.TIMEOUT(8)) dut_s (
        .sys_clk(sys_clk), .reset(s_reset), .enable(s_enable), .ch_mask(s_mask),
        .command_valid(s_cmd_valid), .command_channel(s_cmd_channel),
        .command_startofpacket(s_sop), .command_endofpacket(s_eop),
        .command_ready(s_ready), .response_valid(s_rsp_valid),
        .response_channel(s_rsp_channel), .response_data(s_rsp_data),
        .result_valid(s_result_valid), .result_slot(s_result_slot), .result_data(s_result_data),
        .ch_data(s_ch_data), .timeout_pulse(s_timeout_pulse), .err_count(s_err_count), .busy(s_busy)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        enable         = 1'b0;
        response_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_cmd(output int n);
        n = 0;
        while (command_valid !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
    endtask

    // One transaction with command_ready high: the beat is sampled `delay` edges after accept.
    task automatic round(input logic [11:0] data, input int delay, input logic [3:0] mask_after,
                         output logic [4:0] got_ch, output int n);
        wait_cmd(n);
        got_ch = command_channel;
        tick();
        ch_mask = mask_after;
        repeat (delay - 1) tick();
        response_valid   = 1'b1;
        response_channel = got_ch;
        response_data    = data;
        tick();
        response_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({command_valid, command_startofpacket, command_endofpacket, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 0000", {command_valid, command_startofpacket, command_endofpacket, busy});
        end
        checks++;
        if ({command_channel, result_valid, result_slot, result_data, timeout_pulse, err_count} !== 30'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", {command_channel, result_valid, result_slot, result_data, timeout_pulse, err_count});
        end
        checks++;
        if (ch_data !== 48'h0) begin
            failures++;
            $display("FAIL reset_bank: got %h expected 0", ch_data);
        end
    endtask

    task automatic test_round_robin();
        logic [4:0]  ch;
        logic [11:0] d;
        int n;
        do_reset();
        ch_mask       = 4'b1111;
        command_ready = 1'b0;
        enable        = 1'b1;
        tick();
        checks++;
        if ({busy, command_valid} !== 2'b10) begin
            failures++;
            $display("FAIL latency_pick: got busy,valid=%b expected 10", {busy, command_valid});
        end
        tick();
        checks++;
        if ({command_valid, command_startofpacket, command_endofpacket, command_channel} !== {3'b111, 5'd1}) begin
            failures++;
            $display("FAIL latency_cmd: got %b ch=%0d expected 111 ch=1",
                     {command_valid, command_startofpacket, command_endofpacket}, command_channel);
        end
        command_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            d = 12'h100 + 12'(r % 4);
            round(d, 5, 4'b1111, ch, n);
            checks++;
            if (ch !== 5'(1 + r % 4)) begin
                failures++;
                $display("FAIL rr_channel[%0d]: got %0d expected %0d", r, ch, 1 + r % 4);
            end
            checks++;
            if (n !== ((r == 0) ? 0 : 1)) begin
                failures++;
                $display("FAIL rr_cmd_gap[%0d]: got %0d expected %0d", r, n, (r == 0) ? 0 : 1);
            end
            checks++;
            if ({result_valid, result_slot, result_data, command_valid} !== {1'b1, 3'(r % 4), d, 1'b0}) begin
                failures++;
                $display("FAIL rr_result[%0d]: got v=%b slot=%0d data=%h cv=%b expected v=1 slot=%0d data=%h cv=0",
                         r, result_valid, result_slot, result_data, command_valid, r % 4, d);
            end
            if (r == 3) begin
                checks++;
                if (ch_data !== 48'h103102101100) begin
                    failures++;
                    $display("FAIL rr_bank: got %h expected 103102101100", ch_data);
                end
            end
        end
        tick();
        checks++;
        if (result_valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_pulse_width: got %b expected 0", result_valid);
        end
    endtask

    task automatic test_mask();
        logic [4:0] ch;
        int n;
        logic [4:0] exp_ch [5] = '{5'd2, 5'd4, 5'd2, 5'd4, 5'd1};
        logic [3:0] masks  [5] = '{4'b1010, 4'b1010, 4'b1010, 4'b0001, 4'b0001};
        do_reset();
        ch_mask       = 4'b1010;
        command_ready = 1'b1;
        enable        = 1'b1;
        for (int i = 0; i < 5; i++) begin
            round(12'h200 + 12'(i), 3, masks[i], ch, n);
            checks++;
            if (ch !== exp_ch[i] || result_valid !== 1'b1 || result_data !== 12'h200 + 12'(i)) begin
                failures++;
                $display("FAIL mask_seq[%0d]: got ch=%0d v=%b data=%h expected ch=%0d v=1 data=%h",
                         i, ch, result_valid, result_data, exp_ch[i], 12'h200 + 12'(i));
            end
        end
    endtask

    task automatic test_hold_ready();
        int n;
        bit bad;
        do_reset();
        ch_mask       = 4'b1111;
        command_ready = 1'b0;
        enable        = 1'b1;
        wait_cmd(n);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 5) enable = 1'b0;
            if (command_valid !== 1'b1 || command_channel !== 5'd1) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL hold_stable: got unstable command expected valid=1 ch=1 for 20 cycles");
        end
        command_ready = 1'b1;
        tick();
        checks++;
        if ({command_valid, busy} !== 2'b01) begin
            failures++;
            $display("FAIL hold_accept: got valid,busy=%b expected 01", {command_valid, busy});
        end
        tick();
        tick();
        response_valid   = 1'b1;
        response_channel = 5'd1;
        response_data    = 12'h0AB;
        tick();
        response_valid = 1'b0;
        checks++;
        if ({result_valid, result_data, busy} !== {1'b1, 12'h0AB, 1'b0}) begin
            failures++;
            $display("FAIL hold_finish: got v=%b data=%h busy=%b expected v=1 data=0ab busy=0",
                     result_valid, result_data, busy);
        end
        repeat (3) tick();
        checks++;
        if ({command_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL hold_idle: got valid,busy=%b expected 00", {command_valid, busy});
        end
    endtask

    task automatic test_timeout();
        logic [4:0] ch;
        int n;
        bit bad;
        do_reset();
        ch_mask       = 4'b1111;
        command_ready = 1'b1;
        enable        = 1'b1;
        round(12'h5A5, 2, 4'b1111, ch, n);
        wait_cmd(n);
        checks++;
        if (command_channel !== 5'd2) begin
            failures++;
            $display("FAIL to_cmd: got ch=%0d expected 2", command_channel);
        end
        tick();
        bad = 1'b0;
        repeat (1022) begin
            tick();
            if (timeout_pulse !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL to_early: got early timeout_pulse expected none before 1023 cycles");
        end
        tick();
        checks++;
        if ({timeout_pulse, err_count, result_valid} !== {1'b1, 8'd1, 1'b0}) begin
            failures++;
            $display("FAIL to_fire: got pulse=%b err=%0d rv=%b expected pulse=1 err=1 rv=0",
                     timeout_pulse, err_count, result_valid);
        end
        checks++;
        if (ch_data !== 48'h0000000005A5) begin
            failures++;
            $display("FAIL to_bank: got %h expected 0000000005a5", ch_data);
        end
        tick();
        wait_cmd(n);
        checks++;
        if ({timeout_pulse, command_valid, command_channel} !== {2'b01, 5'd3}) begin
            failures++;
            $display("FAIL to_next: got pulse=%b valid=%b ch=%0d expected pulse=0 valid=1 ch=3",
                     timeout_pulse, command_valid, command_channel);
        end
    endtask

    task automatic test_wrong_channel();
        int n;
        tick();
        tick();
        tick();
        response_valid   = 1'b1;
        response_channel = 5'd7;
        response_data    = 12'hBAD;
        tick();
        response_valid = 1'b0;
        checks++;
        if ({result_valid, busy} !== 2'b01) begin
            failures++;
            $display("FAIL wrong_ignored: got rv,busy=%b expected 01", {result_valid, busy});
        end
        tick();
        tick();
        response_valid   = 1'b1;
        response_channel = 5'd3;
        response_data    = 12'h333;
        tick();
        response_valid = 1'b0;
        checks++;
        if ({result_valid, result_slot, result_data, timeout_pulse} !== {1'b1, 3'd2, 12'h333, 1'b0}) begin
            failures++;
            $display("FAIL wrong_then_right: got v=%b slot=%0d data=%h to=%b expected v=1 slot=2 data=333 to=0",
                     result_valid, result_slot, result_data, timeout_pulse);
        end
        checks++;
        if (ch_data !== 48'h0003330005A5) begin
            failures++;
            $display("FAIL wrong_bank: got %h expected 0003330005a5", ch_data);
        end
        wait_cmd(n);
        checks++;
        if (command_channel !== 5'd4) begin
            failures++;
            $display("FAIL edge_cmd: got ch=%0d expected 4", command_channel);
        end
        tick();
        repeat (1022) tick();
        response_valid   = 1'b1;
        response_channel = 5'd4;
        response_data    = 12'h444;
        tick();
        response_valid = 1'b0;
        checks++;
        if ({result_valid, result_data, timeout_pulse, err_count} !== {1'b1, 12'h444, 1'b0, 8'd1}) begin
            failures++;
            $display("FAIL edge_match_wins: got v=%b data=%h to=%b err=%0d expected v=1 data=444 to=0 err=1",
                     result_valid, result_data, timeout_pulse, err_count);
        end
        checks++;
        if (ch_data !== 48'h4443330005A5) begin
            failures++;
            $display("FAIL edge_bank: got %h expected 4443330005a5", ch_data);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        wait_cmd(n);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({command_valid, busy, result_valid, timeout_pulse, err_count, command_channel} !== 17'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got cv=%b busy=%b rv=%b to=%b err=%0d ch=%0d expected all 0",
                     command_valid, busy, result_valid, timeout_pulse, err_count, command_channel);
        end
        checks++;
        if ({ch_data, result_data, result_slot} !== 63'd0) begin
            failures++;
            $display("FAIL midreset_bank: got bank=%h data=%h slot=%0d expected 0", ch_data, result_data, result_slot);
        end
        ch_mask = 4'b1100;
        reset   = 1'b0;
        wait_cmd(n);
        checks++;
        if ({command_valid, command_channel} !== {1'b1, 5'd3}) begin
            failures++;
            $display("FAIL midreset_first: got valid=%b ch=%0d expected valid=1 ch=3", command_valid, command_channel);
        end
    endtask

    task automatic test_saturation();
        int count;
        int cyc;
        s_reset = 1'b0;
        count   = 0;
        cyc     = 0;
        while (count < 300 && cyc < 8000) begin
            tick();
            cyc++;
            if (s_timeout_pulse === 1'b1) begin
                count++;
                if (count == 10) begin
                    checks++;
                    if (s_err_count !== 8'd10) begin
                        failures++;
                        $display("FAIL sat_count10: got %0d expected 10", s_err_count);
                    end
                end
            end
        end
        checks++;
        if (count !== 300) begin
            failures++;
            $display("FAIL sat_pulses: got %0d expected 300", count);
        end
        checks++;
        if (s_err_count !== 8'd255) begin
            failures++;
            $display("FAIL sat_value: got %0d expected 255", s_err_count);
        end
    endtask

    initial begin
        reset            = 1'b1;
        enable           = 1'b0;
        ch_mask          = 4'b0000;
        command_ready    = 1'b0;
        response_valid   = 1'b0;
        response_channel = 5'd0;
        response_data    = 12'h000;
        s_reset          = 1'b1;
        s_enable         = 1'b1;
        s_mask           = 4'b1111;
        s_ready          = 1'b1;
        s_rsp_valid      = 1'b0;
        s_rsp_channel    = 5'd0;
        s_rsp_data       = 12'h000;

        test_reset();
        test_round_robin();
        test_mask();
        test_hold_ready();
        test_timeout();
        test_wrong_channel();
        test_reset_mid();
        test_saturation();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
